// File: rtl/at25010_pkg.sv
// rtl/at25010_pkg.sv - AT25010 opcodes, status bit layout, block-protect bounds and FSM states
package at25010_pkg;

    // Opcode bit 3 carries A8 on larger parts and is ignored here
    localparam logic [7:0] OP_MASK  = 8'hF7;
    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    localparam int SR_RDY_N = 0;
    localparam int SR_WEN   = 1;
    localparam int SR_BP0   = 2;
    localparam int SR_BP1   = 3;

    localparam logic [7:0] BP1_LO = 8'h60;
    localparam logic [7:0] BP2_LO = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_RDSR,
        ST_WRSR_DATA,
        ST_IGNORE
    } state_e;

    function automatic logic bp_protects(input logic [1:0] bp, input logic [7:0] addr);
        case (bp)
            2'b01:   bp_protects = (addr >= BP1_LO);
            2'b10:   bp_protects = (addr >= BP2_LO);
            2'b11:   bp_protects = 1'b1;
            default: bp_protects = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_mode0_slave_shifter.sv
// rtl/spi_mode0_slave_shifter.sv - SPI mode-0 bit engine: oversampled edge detect, rx byte strobe, tx shift
module spi_mode0_slave_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [2:0] bit_cnt,
    output logic       cs_fall,
    output logic       cs_rise
);
    logic       sclk_q;
    logic       cs_q;
    logic       miso_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_sh_q;
    logic [7:0] tx_sh_q;
    logic       rise;
    logic       fall;

    // Chip select gates both edges so a deassert in the same cycle wins
    assign rise     = sclk & ~sclk_q & ~cs_n;
    assign fall     = ~sclk & sclk_q & ~cs_n;
    assign cs_fall  = ~cs_n & cs_q;
    assign cs_rise  = cs_n & ~cs_q;
    assign rx_valid = rise & (bit_cnt_q == 3'd7);
    assign rx_byte  = {rx_sh_q, mosi};
    assign bit_cnt  = bit_cnt_q;
    assign miso     = miso_q & ~cs_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            miso_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            rx_sh_q   <= 7'd0;
            tx_sh_q   <= 8'd0;
        end else begin
            sclk_q <= sclk;
            cs_q   <= cs_n;
            if (cs_n) begin
                bit_cnt_q <= 3'd0;
                tx_sh_q   <= 8'd0;
                miso_q    <= 1'b0;
            end else begin
                if (rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    rx_sh_q   <= {rx_sh_q[5:0], mosi};
                end
                // The fall that follows a byte boundary presents the next byte's MSB
                if (fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        miso_q  <= tx_byte[7];
                        tx_sh_q <= {tx_byte[6:0], 1'b0};
                    end else begin
                        miso_q  <= tx_sh_q[7];
                        tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/at25010_spi_responder.sv
// rtl/at25010_spi_responder.sv - AT25010 EEPROM emulator top; AT25010_BACKDOOR_EN adds a direct memory port
module at25010_spi_responder #(
    parameter int         ADDR_W       = 7,
    parameter int         PAGE_BYTES   = 8,
    parameter int         WRITE_CYCLES = 500,
    parameter logic [7:0] MEM_INIT     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              busy,
`ifdef AT25010_BACKDOOR_EN
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata,
`endif
    output logic              wr_commit
);
    import at25010_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PB    = $clog2(PAGE_BYTES);
    localparam int TW    = $clog2(WRITE_CYCLES + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                op_rd_q, wen_q, busy_q, wr_commit_q, data_seen_q;
    logic [1:0]          bp_q, bp_new_q;
    logic [TW-1:0]       timer_q;
    logic [7:0]          mem_q  [DEPTH];
    logic [7:0]          pbuf_q [PAGE_BYTES];
    logic [PAGE_BYTES-1:0] mask_q;

    logic [7:0] rx_byte, tx_byte, opcode, status;
    logic       rx_valid, cs_fall, cs_rise;
    logic [2:0] bit_cnt;
    logic       set_wen, clr_wen, dec, dec_rd, load_addr, addr_inc, buf_wr, cap_bp, mark_data;
    logic       commit, commit_wr;
    logic [ADDR_W-1:0]     slot_addr [PAGE_BYTES];
    logic [PAGE_BYTES-1:0] slot_we;

    spi_mode0_slave_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (spi_cs_n),
        .sclk     (spi_sclk),
        .mosi     (spi_mosi),
        .tx_byte  (tx_byte),
        .miso     (spi_miso),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .bit_cnt  (bit_cnt),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    assign busy      = busy_q;
    assign wr_commit = wr_commit_q;
    assign opcode    = rx_byte & OP_MASK;
`ifdef AT25010_BACKDOOR_EN
    assign bd_rdata  = mem_q[bd_addr];
`endif

    always_comb begin
        status           = 8'h00;
        status[SR_RDY_N] = busy_q;
        status[SR_WEN]   = wen_q;
        status[SR_BP0]   = bp_q[0];
        status[SR_BP1]   = bp_q[1];
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_RD_DATA: tx_byte = mem_q[addr_q];
            ST_RDSR:    tx_byte = status;
            default:    tx_byte = 8'h00;
        endcase
    end

    // Commit sees the state and bit count as they stood when CS rose
    assign commit = cs_rise & wen_q & ~busy_q & (bit_cnt == 3'd0) & data_seen_q &
                    ((state_q == ST_WR_DATA) | (state_q == ST_WRSR_DATA));
    assign commit_wr = commit & (state_q == ST_WR_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        set_wen   = 1'b0;
        clr_wen   = 1'b0;
        dec       = 1'b0;
        dec_rd    = 1'b0;
        load_addr = 1'b0;
        addr_inc  = 1'b0;
        buf_wr    = 1'b0;
        cap_bp    = 1'b0;
        mark_data = 1'b0;
        if (spi_cs_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_OPCODE;
                ST_OPCODE: if (rx_valid) begin
                    state_d = ST_IGNORE;
                    if (!busy_q || opcode == OP_RDSR) begin
                        case (opcode)
                            OP_WREN:  set_wen = 1'b1;
                            OP_WRDI:  clr_wen = 1'b1;
                            OP_READ:  begin dec = 1'b1; dec_rd = 1'b1; state_d = ST_ADDR; end
                            OP_WRITE: begin dec = 1'b1; state_d = ST_ADDR; end
                            OP_RDSR:  state_d = ST_RDSR;
                            OP_WRSR:  state_d = ST_WRSR_DATA;
                            default:  state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: if (rx_valid) begin
                    load_addr = 1'b1;
                    state_d   = op_rd_q ? ST_RD_DATA : ST_WR_DATA;
                end
                ST_RD_DATA: addr_inc = rx_valid;
                ST_WR_DATA: begin
                    buf_wr    = rx_valid;
                    mark_data = rx_valid;
                end
                ST_WRSR_DATA: begin
                    cap_bp    = rx_valid & ~data_seen_q;
                    mark_data = rx_valid;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            op_rd_q     <= 1'b0;
            wen_q       <= 1'b0;
            bp_q        <= 2'b00;
            bp_new_q    <= 2'b00;
            data_seen_q <= 1'b0;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            timer_q     <= '0;
            wr_commit_q <= 1'b0;
            for (int i = 0; i < PAGE_BYTES; i++) pbuf_q[i] <= 8'h00;
        end else begin
            wr_commit_q <= commit;
            if (set_wen)               wen_q <= 1'b1;
            else if (clr_wen || commit) wen_q <= 1'b0;
            if (commit && !commit_wr)  bp_q <= bp_new_q;
            if (cap_bp)                bp_new_q <= rx_byte[3:2];
            if (dec)                   op_rd_q <= dec_rd;
            if (cs_fall)               data_seen_q <= 1'b0;
            else if (mark_data)        data_seen_q <= 1'b1;

            // Writes wrap within the page; reads walk the whole array
            if (load_addr)     addr_q <= rx_byte[ADDR_W-1:0];
            else if (addr_inc) addr_q <= addr_q + ADDR_W'(1);
            else if (buf_wr)   addr_q <= {addr_q[ADDR_W-1:PB], addr_q[PB-1:0] + PB'(1)};

            if (load_addr) mask_q <= '0;
            if (buf_wr) begin
                pbuf_q[addr_q[PB-1:0]] <= rx_byte;
                mask_q[addr_q[PB-1:0]] <= 1'b1;
            end

            if (commit) begin
                busy_q  <= 1'b1;
                timer_q <= TW'(WRITE_CYCLES - 1);
            end else if (busy_q) begin
                if (timer_q == '0) busy_q <= 1'b0;
                else               timer_q <= timer_q - TW'(1);
            end
        end
    end

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < PAGE_BYTES; i++) begin
            slot_addr[i] = {addr_q[ADDR_W-1:PB], PB'(i)};
            slot_we[i]   = commit_wr & mask_q[i] & ~bp_protects(bp_q, 8'(slot_addr[i]));
        end
    end

    // Commit writes come after the backdoor so they win a same-byte collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= MEM_INIT;
        end else begin
`ifdef AT25010_BACKDOOR_EN
            if (bd_we) mem_q[bd_addr] <= bd_wdata;
`endif
            for (int i = 0; i < PAGE_BYTES; i++) begin
                if (slot_we[i]) mem_q[slot_addr[i]] <= pbuf_q[i];
            end
        end
    end

endmodule
